// File: rtl/cla_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// cla_arbiter_pkg
// Shared constants and types for the two-requester adder arbiter and the
// cla32 carry-lookahead adder it wraps.
//   ADD_W   : adder operand width
//   NUM_REQ : number of requesters sharing the adder
//   GRP_W   : lookahead group size used inside cla32
// -----------------------------------------------------------------------------
package cla_arbiter_pkg;

  localparam int ADD_W   = 32;
  localparam int NUM_REQ = 2;
  localparam int GRP_W   = 4;

  typedef logic [ADD_W-1:0] word_t;

endpackage

// File: rtl/cla_arbiter_cla32.sv
// -----------------------------------------------------------------------------
// cla32
// 32-bit carry-lookahead adder, purely combinational.
// Full lookahead inside each 4-bit group; group generate/propagate terms
// chain the carry from group to group.
// Ports:
//   a, b : operands
//   ci   : carry-in
//   s    : sum modulo 2^32
//   co   : carry out of bit 31
// -----------------------------------------------------------------------------
module cla32
  import cla_arbiter_pkg::*;
(
  input  logic [ADD_W-1:0] a,
  input  logic [ADD_W-1:0] b,
  input  logic             ci,
  output logic [ADD_W-1:0] s,
  output logic             co
);

  localparam int NGRP = ADD_W / GRP_W;

  logic [ADD_W-1:0] g;
  logic [ADD_W-1:0] p;
  logic [ADD_W-1:0] c;
  logic [NGRP:0]    gc;   // carry into each group, gc[NGRP] is the final carry

  assign g     = a & b;
  assign p     = a ^ b;
  assign gc[0] = ci;

  generate
    for (genvar gi = 0; gi < NGRP; gi++) begin : g_grp
      localparam int B = gi * GRP_W;
      logic grp_g;
      logic grp_p;

      assign c[B]   = gc[gi];
      assign c[B+1] = g[B] | (p[B] & gc[gi]);
      assign c[B+2] = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & gc[gi]);
      assign c[B+3] = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                    | (p[B+2] & p[B+1] & p[B] & gc[gi]);

      assign grp_g = g[B+3] | (p[B+3] & g[B+2]) | (p[B+3] & p[B+2] & g[B+1])
                   | (p[B+3] & p[B+2] & p[B+1] & g[B]);
      assign grp_p = &p[B+3:B];

      assign gc[gi+1] = grp_g | (grp_p & gc[gi]);
    end
  endgenerate

  assign s  = p ^ c;
  assign co = gc[NGRP];

endmodule

// File: rtl/cla_arbiter.sv
// -----------------------------------------------------------------------------
// cla_arbiter
// Shares one cla32 between two requesters through a two-stage pipeline:
//   S1 : captured operands feeding cla32
//   S2 : registered sum/carry driving the response port
// Round-robin arbitration with a 1-bit last-grant pointer.
// Ports:
//   clk, reset_n                  : clock, async active-low reset
//   reqN_valid/a/b/ci, reqN_ready : request ports (N = 0, 1), valid/ready
//   rsp_valid/id/s/co, rsp_ready  : response port, valid/ready
//   busy                          : either pipeline stage occupied
// -----------------------------------------------------------------------------
module cla_arbiter
  import cla_arbiter_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req0_valid,
  input  logic [ADD_W-1:0] req0_a,
  input  logic [ADD_W-1:0] req0_b,
  input  logic             req0_ci,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [ADD_W-1:0] req1_a,
  input  logic [ADD_W-1:0] req1_b,
  input  logic             req1_ci,
  output logic             req1_ready,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [ADD_W-1:0] rsp_s,
  output logic             rsp_co,
  input  logic             rsp_ready,
  output logic             busy
);

  logic               s1_valid_reg;
  logic               s1_id_reg;
  word_t              s1_a_reg;
  word_t              s1_b_reg;
  logic               s1_ci_reg;
  logic               s2_valid_reg;
  logic               s2_id_reg;
  word_t              s2_s_reg;
  logic               s2_co_reg;
  logic               last_grant_reg;

  logic [NUM_REQ-1:0] grant;
  logic               s2_load;
  logic               accept_en;
  logic               handshake;
  word_t              sum;
  logic               sum_co;

  // S2 can take new data when empty or being drained this cycle; S1 can
  // take a new op when empty or when it moves into S2 this cycle.
  assign s2_load   = !s2_valid_reg || rsp_ready;
  assign accept_en = !s1_valid_reg || s2_load;

  // On contention the requester other than the last winner gets the grant.
  always_comb begin
    grant    = '0;
    grant[0] = req0_valid && (!req1_valid || last_grant_reg);
    grant[1] = req1_valid && (!req0_valid || !last_grant_reg);
  end

  // reset_n is folded in because the cleared pipeline would otherwise
  // report space available while reset is held.
  assign req0_ready = reset_n && accept_en && grant[0];
  assign req1_ready = reset_n && accept_en && grant[1];
  assign handshake  = req0_ready || req1_ready;

  cla32 u_cla32 (
    .a  (s1_a_reg),
    .b  (s1_b_reg),
    .ci (s1_ci_reg),
    .s  (sum),
    .co (sum_co)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_reg   <= 1'b0;
      s1_id_reg      <= 1'b0;
      s2_valid_reg   <= 1'b0;
      s2_id_reg      <= 1'b0;
      s2_s_reg       <= '0;
      s2_co_reg      <= 1'b0;
      last_grant_reg <= 1'b1;
    end else begin
      if (accept_en) begin
        s1_valid_reg <= handshake;
      end
      if (handshake) begin
        s1_id_reg      <= grant[1];
        last_grant_reg <= grant[1];
      end
      if (s2_load) begin
        s2_valid_reg <= s1_valid_reg;
        if (s1_valid_reg) begin
          s2_id_reg <= s1_id_reg;
          s2_s_reg  <= sum;
          s2_co_reg <= sum_co;
        end
      end
    end
  end

  // Operand registers need no reset: they are only observed behind s1_valid.
  always_ff @(posedge clk) begin
    if (handshake) begin
      s1_a_reg  <= grant[1] ? req1_a  : req0_a;
      s1_b_reg  <= grant[1] ? req1_b  : req0_b;
      s1_ci_reg <= grant[1] ? req1_ci : req0_ci;
    end
  end

  assign rsp_valid = s2_valid_reg;
  assign rsp_id    = s2_id_reg;
  assign rsp_s     = s2_s_reg;
  assign rsp_co    = s2_co_reg;
  assign busy      = s1_valid_reg || s2_valid_reg;

endmodule

// File: tb/tb_cla_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cla_arbiter
// Self-checking bench for cla_arbiter: a table of single-op vectors with
// hand-computed results, directed contention/backpressure/reset sequences,
// and a randomized run checked by an in-order scoreboard.
// -----------------------------------------------------------------------------
module tb_cla_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req0_valid, req0_ci, req0_ready;
  logic [31:0] req0_a, req0_b;
  logic        req1_valid, req1_ci, req1_ready;
  logic [31:0] req1_a, req1_b;
  logic        rsp_valid, rsp_id, rsp_co, rsp_ready, busy;
  logic [31:0] rsp_s;

  int nchecks = 0;
  int nerrors = 0;
  int nrsp    = 0;

  always #5 clk = ~clk;

  cla_arbiter dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req0_valid (req0_valid),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_ci    (req0_ci),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_ci    (req1_ci),
    .req1_ready (req1_ready),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_s      (rsp_s),
    .rsp_co     (rsp_co),
    .rsp_ready  (rsp_ready),
    .busy       (busy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_ci = 1'b0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_ci = 1'b0;
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    step();
  endtask

  // Scoreboard: expected results in acceptance order, sampled on negedge.
  typedef struct {
    logic        id;
    logic [32:0] sum;
  } exp_t;
  exp_t sb[$];

  always @(negedge clk) begin
    if (!reset_n) begin
      sb.delete();
    end else begin
      chk("ready_onehot", 64'(req0_ready & req1_ready), 64'd0);
      if (req0_valid && req0_ready)
        sb.push_back('{1'b0, {1'b0, req0_a} + {1'b0, req0_b} + 33'(req0_ci)});
      if (req1_valid && req1_ready)
        sb.push_back('{1'b1, {1'b0, req1_a} + {1'b0, req1_b} + 33'(req1_ci)});
      if (rsp_valid && rsp_ready) begin
        exp_t e;
        nrsp++;
        if (sb.size() == 0) begin
          nchecks++;
          nerrors++;
          $display("FAIL sb_unexpected: got response id=%0d s=0x%0h, expected none", rsp_id, rsp_s);
        end else begin
          e = sb.pop_front();
          chk("sb_id", 64'(rsp_id), 64'(e.id));
          chk("sb_sum", 64'({rsp_co, rsp_s}), 64'(e.sum));
        end
      end
    end
  end

  typedef struct {
    logic        v0, v1;
    logic [31:0] a, b;
    logic        ci;
    logic        rdy0, rdy1;
    logic [31:0] s;
    logic        co;
    logic        id;
  } vec_t;
  vec_t vecs[8];

  initial begin
    int acc;
    int cnt;
    int cyc;
    int nrsp0;

    reset_n = 1'b0;
    rsp_ready = 1'b0;
    idle_inputs();

    // Reset state, including ready suppression while reset is held.
    repeat (2) @(posedge clk);
    #1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_rsp_id", 64'(rsp_id), 64'd0);
    chk("rst_rsp_s", 64'(rsp_s), 64'd0);
    chk("rst_rsp_co", 64'(rsp_co), 64'd0);
    chk("rst_ready0", 64'(req0_ready), 64'd0);
    chk("rst_ready1", 64'(req1_ready), 64'd0);
    idle_inputs();
    step();
    reset_n = 1'b1;
    step();

    // Table: pointer starts at 1 (requester 0 wins first contention).
    vecs[0] = '{1'b1, 1'b0, 32'h00000005, 32'h00000003, 1'b0, 1'b1, 1'b0, 32'h00000008, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b1};
    vecs[2] = '{1'b1, 1'b0, 32'h80000000, 32'h80000000, 1'b0, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 32'h12345678, 32'h11111111, 1'b1, 1'b0, 1'b1, 32'h2345678A, 1'b0, 1'b1};
    vecs[4] = '{1'b1, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 1'b1, 32'h00000000, 1'b0, 1'b1};
    vecs[6] = '{1'b1, 1'b1, 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b1, 1'b0, 32'h80000000, 1'b0, 1'b0};
    vecs[7] = '{1'b1, 1'b0, 32'hDEADBEEF, 32'h01010101, 1'b0, 1'b1, 1'b0, 32'hDFAEBFF0, 1'b0, 1'b0};

    rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      req0_valid = vecs[i].v0; req0_a = vecs[i].a; req0_b = vecs[i].b; req0_ci = vecs[i].ci;
      req1_valid = vecs[i].v1; req1_a = vecs[i].a; req1_b = vecs[i].b; req1_ci = vecs[i].ci;
      #1;
      chk($sformatf("vec%0d_ready0", i), 64'(req0_ready), 64'(vecs[i].rdy0));
      chk($sformatf("vec%0d_ready1", i), 64'(req1_ready), 64'(vecs[i].rdy1));
      step();
      // Scramble operands after the handshake: the captured copy must win.
      idle_inputs();
      req0_a = ~vecs[i].a; req1_b = ~vecs[i].b;
      #1;
      chk($sformatf("vec%0d_lat1_valid", i), 64'(rsp_valid), 64'd0);
      chk($sformatf("vec%0d_busy", i), 64'(busy), 64'd1);
      step();
      chk($sformatf("vec%0d_rsp_valid", i), 64'(rsp_valid), 64'd1);
      chk($sformatf("vec%0d_rsp_id", i), 64'(rsp_id), 64'(vecs[i].id));
      chk($sformatf("vec%0d_rsp_s", i), 64'(rsp_s), 64'(vecs[i].s));
      chk($sformatf("vec%0d_rsp_co", i), 64'(rsp_co), 64'(vecs[i].co));
      step();
      chk($sformatf("vec%0d_drained", i), 64'(busy), 64'd0);
      idle_inputs();
    end

    // Contention right after reset: grants 0,1,0,1 and matching responses.
    pulse_reset();
    rsp_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (c < 4) begin
        req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd1; req0_ci = 1'b0;
        req1_valid = 1'b1; req1_a = 32'd2; req1_b = 32'd2; req1_ci = 1'b0;
      end else begin
        idle_inputs();
      end
      #1;
      if (c < 4) begin
        chk($sformatf("cont%0d_ready0", c), 64'(req0_ready), 64'(c % 2 == 0));
        chk($sformatf("cont%0d_ready1", c), 64'(req1_ready), 64'(c % 2 == 1));
      end
      if (c >= 2 && c < 6) begin
        chk($sformatf("cont%0d_rsp_valid", c), 64'(rsp_valid), 64'd1);
        chk($sformatf("cont%0d_rsp_id", c), 64'(rsp_id), 64'((c - 2) % 2));
        chk($sformatf("cont%0d_rsp_s", c), 64'(rsp_s), ((c - 2) % 2 == 1) ? 64'd4 : 64'd2);
      end
      step();
    end

    // Backpressure: two ops fit in the pipe, then req0_ready drops.
    rsp_ready = 1'b0;
    acc = 0;
    for (int k = 0; k < 5; k++) begin
      req0_valid = 1'b1; req0_a = 32'(100 + acc); req0_b = '0; req0_ci = 1'b0;
      #1;
      if (k == 4) chk("bp_ready_low", 64'(req0_ready), 64'd0);
      if (req0_ready) acc++;
      step();
    end
    chk("bp_accepted", 64'(acc), 64'd2);
    chk("bp_hold_valid", 64'(rsp_valid), 64'd1);
    chk("bp_hold_s", 64'(rsp_s), 64'd100);
    idle_inputs();
    rsp_ready = 1'b1;
    cnt = 0;
    for (int k = 0; k < 6; k++) begin
      #1;
      if (rsp_valid) begin
        chk($sformatf("bp_drain%0d_s", cnt), 64'(rsp_s), 64'(100 + cnt));
        cnt++;
      end
      step();
    end
    chk("bp_drain_count", 64'(cnt), 64'd2);

    // Reset mid-flight with S1 and S2 both full.
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 32'd7; req0_b = 32'd8; req0_ci = 1'b0;
    step();
    step();
    chk("mf_busy_before", 64'(busy), 64'd1);
    chk("mf_valid_before", 64'(rsp_valid), 64'd1);
    reset_n = 1'b0;
    #1;
    chk("mf_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("mf_busy", 64'(busy), 64'd0);
    chk("mf_ready0", 64'(req0_ready), 64'd0);
    chk("mf_rsp_s", 64'(rsp_s), 64'd0);
    idle_inputs();
    step();
    reset_n = 1'b1;
    rsp_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("mf_post%0d_valid", k), 64'(rsp_valid), 64'd0);
    end
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    chk("mf_ptr_ready0", 64'(req0_ready), 64'd1);
    chk("mf_ptr_ready1", 64'(req1_ready), 64'd0);
    idle_inputs();
    step();

    // Randomized traffic, checked by the scoreboard.
    nrsp0 = nrsp;
    acc = 0;
    cyc = 0;
    while (acc < 1000 && cyc < 20000) begin
      req0_valid = 1'($urandom_range(0, 1));
      req0_a = $urandom; req0_b = $urandom; req0_ci = 1'($urandom_range(0, 1));
      req1_valid = 1'($urandom_range(0, 1));
      req1_a = $urandom; req1_b = $urandom; req1_ci = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) req0_a = 32'hFFFFFFFF;
      if ($urandom_range(0, 7) == 0) req1_b = 32'h80000000;
      rsp_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (req0_valid && req0_ready) acc++;
      if (req1_valid && req1_ready) acc++;
      step();
      cyc++;
    end
    chk("rand_accepted", 64'(acc >= 1000), 64'd1);
    idle_inputs();
    rsp_ready = 1'b1;
    cyc = 0;
    while (busy && cyc < 50) begin
      step();
      cyc++;
    end
    step();
    chk("rand_drain_idle", 64'(busy), 64'd0);
    chk("rand_sb_empty", 64'(sb.size()), 64'd0);
    chk("rand_rsp_count", 64'(nrsp - nrsp0), 64'(acc));

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule

// File: doc/cla_arbiter.md
CLA_ARBITER -- requirements
Module: cla_arbiter

Interface
REQ-001 The block SHALL have no parameters; the operand width is fixed at 32 bits to match cla32.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset_n  input  1  reset, asynchronous assert and active-low; see Reset.
REQ-004 req0_valid  input  1  requester 0 presents an add operation.
REQ-005 req0_a, req0_b  input  32 each  requester 0 operands.
REQ-006 req0_ci  input  1  requester 0 carry-in.
REQ-007 req0_ready  output  1  requester 0 operation accepted this cycle when high together with req0_valid.
REQ-008 req1_valid, req1_a, req1_b, req1_ci, req1_ready  SHALL be identical to REQ-004..007 for requester 1.
REQ-009 rsp_valid  output  1  result available.
REQ-010 rsp_id  output  1  index of the requester that owns the result.
REQ-011 rsp_s  output  32  sum.
REQ-012 rsp_co  output  1  carry-out.
REQ-013 rsp_ready  input  1  consumer takes the result when high together with rsp_valid.
REQ-014 busy  output  1  high while either pipeline stage holds an operation.

Function
REQ-015 The block SHALL share one cla32 instance between the two requesters through a two-stage pipeline: S1 (operand register feeding cla32) and S2 (result register driving the rsp_* outputs).
REQ-016 A handshake on reqN SHALL produce rsp_valid with rsp_id=N exactly 2 cycles later when rsp_ready is held high.
REQ-017 Under sustained traffic with rsp_ready high, one operation SHALL be accepted per cycle.
REQ-018 S2 SHALL hold its contents while rsp_valid=1 and rsp_ready=0.
REQ-019 S2 SHALL load from S1 when S2 is empty or is being consumed this cycle.
REQ-020 S1 SHALL accept a new operation only when S1 is empty or S1 advances into S2 this cycle (accept_en).
REQ-021 Arbitration SHALL be round-robin with a 1-bit last-grant pointer.
REQ-022 If only one requester is valid, that requester SHALL be granted.
REQ-023 If both requesters are valid, the requester not equal to the last-grant pointer SHALL be granted.
REQ-024 reqN_ready SHALL equal accept_en AND grantN, and SHALL be combinational from the valids and the pipeline state.
REQ-025 reqN_ready SHALL NOT depend on the operand inputs.
REQ-026 The last-grant pointer SHALL update only on a completed handshake.
REQ-027 At most one of req0_ready and req1_ready SHALL be high in any cycle.
REQ-028 The sum SHALL be computed modulo 2^32, and co SHALL be the bit-32 carry of a+b+ci.
REQ-029 The results SHALL be bit-exact with cla32 for all operand values, including 0xFFFFFFFF+0x00000000+1, which gives s=0 and co=1.
REQ-030 Results SHALL be returned in acceptance order; no reordering and no drops are permitted.
REQ-031 Operands SHALL be captured at the handshake, so the requester may change them the following cycle.
REQ-032 busy SHALL equal S1_valid OR S2_valid.

Reset
REQ-033 Asserting reset_n low SHALL, immediately and independently of clk, set S1_valid=0, S2_valid=0, rsp_valid=0, busy=0, rsp_id=0, rsp_s=0 and rsp_co=0.
REQ-034 Asserting reset_n low SHALL set the last-grant pointer to 1, so requester 0 wins the first contention.
REQ-035 A reset asserted mid-operation SHALL discard all in-flight operations; no result for them SHALL appear after reset is released.
REQ-036 reqN_ready SHALL be 0 while reset_n is low.
REQ-037 Operand datapath registers MAY be left unreset.

Structure
REQ-038 The adder width (32) and the requester count (2) SHALL be constants in the shared project package.
REQ-039 The adder SHALL be an instantiation of the existing cla32; no other sub-module is required.
REQ-040 The block SHALL contain no combinational path from rsp_ready to rsp_valid.

Verification
REQ-041 Single op: req0 (a=0x00000005, b=0x00000003, ci=0) with rsp_ready=1 -> rsp_valid 2 cycles later with s=0x00000008, co=0, id=0.
REQ-042 Contention: both requesters valid continuously (req0 a=1,b=1; req1 a=2,b=2; ci=0) for 4 cycles after reset -> grant order 0,1,0,1; responses s=2,4,2,4 with ids 0,1,0,1.
REQ-043 Backpressure: rsp_ready=0 for 5 cycles with req0 always valid -> exactly 2 operations accepted, then req0_ready=0; after rsp_ready=1, results drain in order with none lost or duplicated.
REQ-044 Carry boundary: a=0xFFFFFFFF, b=0x00000000, ci=1 -> s=0x00000000, co=1; a=0x80000000, b=0x80000000, ci=0 -> s=0, co=1.
REQ-045 Reset mid-flight: assert reset_n low while S1 and S2 are full -> rsp_valid=0 and busy=0 immediately; no rsp_valid pulse within 3 cycles after release when no new request is presented.
REQ-046 Randomized throughput check: 1000 random operations with random valids and random rsp_ready -> every result matches a+b+ci mod 2^33, in per-acceptance order, with the correct rsp_id.
